// File: rtl/phase_meter_pkg.sv
// Shared constants and FSM encoding for the phase meter and its input synchronizer.
package phase_meter_pkg;

   localparam int SYNC_LAT             = 2;
   localparam int TIMEOUT_HALF_PERIODS = 8;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_RISE,
      WAIT_PERIOD,
      DONE
   } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module edge_sync
   import phase_meter_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   // sh_q[0] is the metastability flop; the extra top bit only feeds the edge detector
   logic [SYNC_LAT:0] sh_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) sh_q <= '0;
      else       sh_q <= {sh_q[SYNC_LAT-1:0], d_i};
   end

   assign level_o = sh_q[SYNC_LAT-1];
   assign rise_o  = sh_q[SYNC_LAT-1] & ~sh_q[SYNC_LAT];

endmodule

// File: rtl/phase_meter.sv
// Captures the timebase phase {pol, cnt} of an external square wave's rising edge and its period.
// Period measurement is built only when PHASE_METER_PERIOD_EN is defined.
module phase_meter
   import phase_meter_pkg::*;
#(
   parameter int OFFSET_WIDTH = 11
)(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    sig_in_i,
   input  logic [OFFSET_WIDTH-2:0] divide_i,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    valid_o,
   output logic                    timeout_o,
   output logic [OFFSET_WIDTH-1:0] offset_o,
   output logic [OFFSET_WIDTH:0]   period_o
);

   localparam int CW  = OFFSET_WIDTH - 1;
   localparam int WCW = $clog2(TIMEOUT_HALF_PERIODS);

   state_e                  state_q, state_d;
   logic [CW-1:0]           tcnt_q;
   logic                    tpol_q;
   logic [WCW-1:0]          wcnt_q, wcnt_d;
   logic [OFFSET_WIDTH-1:0] off_q, off_d, cap;
   logic                    to_q, to_d;
   logic                    level, rise, wrap, active, capture, closing;

   edge_sync u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .d_i     (sig_in_i),
      .level_o (level),
      .rise_o  (rise)
   );

   assign wrap = (tcnt_q == divide_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tcnt_q <= '0;
         tpol_q <= 1'b0;
      end else if (wrap) begin
         tcnt_q <= '0;
         tpol_q <= ~tpol_q;
      end else begin
         tcnt_q <= tcnt_q + CW'(1);
      end
   end

   // Back the timebase up by the synchronizer latency, borrowing from the previous half-period
   always_comb begin
      if (tcnt_q >= CW'(SYNC_LAT)) cap = {tpol_q, tcnt_q - CW'(SYNC_LAT)};
      else                         cap = {~tpol_q, tcnt_q + divide_i + CW'(1) - CW'(SYNC_LAT)};
   end

   assign active  = state_q inside {ARM, WAIT_RISE, WAIT_PERIOD};
   assign capture = (state_q == WAIT_RISE) && rise;
   assign closing = (state_q == WAIT_PERIOD) && rise;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      off_d   = off_q;
      to_d    = to_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = ARM;
            wcnt_d  = '0;
         end
         ARM: if (!level) state_d = WAIT_RISE;
         WAIT_RISE: if (rise) begin
            off_d  = cap;
            wcnt_d = '0;
            to_d   = 1'b0;
`ifdef PHASE_METER_PERIOD_EN
            state_d = WAIT_PERIOD;
`else
            state_d = DONE;
`endif
         end
         WAIT_PERIOD: if (rise) begin
            state_d = DONE;
            wcnt_d  = '0;
            to_d    = 1'b0;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A real edge wins over a coincident timeout
      if (active && wrap && !capture && !closing) begin
         if (wcnt_q == WCW'(TIMEOUT_HALF_PERIODS - 1)) begin
            state_d = DONE;
            to_d    = 1'b1;
         end else begin
            wcnt_d = wcnt_q + WCW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         off_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         off_q   <= off_d;
         to_q    <= to_d;
      end
   end

`ifdef PHASE_METER_PERIOD_EN
   logic [OFFSET_WIDTH:0] pcnt_q, pcnt_d, per_q, per_d, pinc;

   assign pinc = (&pcnt_q) ? pcnt_q : pcnt_q + (OFFSET_WIDTH+1)'(1);

   always_comb begin
      pcnt_d = pcnt_q;
      per_d  = per_q;
      if (capture)                     pcnt_d = '0;
      else if (state_q == WAIT_PERIOD) pcnt_d = pinc;
      if (closing)                     per_d  = pinc;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pcnt_q <= '0;
         per_q  <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         per_q  <= per_d;
      end
   end

   assign period_o = per_q;
`else
   assign period_o = '0;
`endif

   assign busy_o    = active;
   assign done_o    = (state_q == DONE);
   assign valid_o   = done_o & ~to_q;
   assign timeout_o = done_o & to_q;
   assign offset_o  = off_q;

endmodule

// File: tb/tb_phase_meter.sv
// Randomized directed bench for phase_meter; expected phases derive from elapsed cycles since reset.
module tb_phase_meter;

   localparam int OW  = 11;
   localparam int HP  = 625;
   localparam int PER = 2 * HP;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sig = 1'b0;
   logic          start = 1'b0;
   logic [OW-2:0] divide = 10'd624;
   logic          busy, done, valid, timeout;
   logic [OW-1:0] offset;
   logic [OW:0]   period;

   phase_meter #(.OFFSET_WIDTH(OW)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .sig_in_i  (sig),
      .divide_i  (divide),
      .start_i   (start),
      .busy_o    (busy),
      .done_o    (done),
      .valid_o   (valid),
      .timeout_o (timeout),
      .offset_o  (offset),
      .period_o  (period)
   );

   always #10 clk = ~clk;

   // Elapsed cycles since reset: the timebase is pol = (t%1250)/625, cnt = t%625
   int t = 0;
   always @(posedge clk) t <= rst ? 0 : t + 1;

   int n_cmp = 0, n_err = 0;
   int done_cnt = 0, d_t = 0;
   logic d_valid, d_to;
   logic [OW-1:0] d_off, last_off = '0;
   logic [OW:0]   d_per, last_per = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         d_t = t; d_valid = valid; d_to = timeout; d_off = offset; d_per = period;
         chk("valid_xor_timeout", 32'(valid) + 32'(timeout), 1);
      end else if (!rst) begin
         chk("flags_outside_done", {30'd0, valid, timeout}, 0);
      end
   end

   function automatic logic [OW-1:0] phase_word(input int p);
      logic [OW-1:0] r;
      r = OW'(p % HP);
      r[OW-1] = ((p / HP) % 2) == 1;
      return r;
   endfunction

   function automatic logic [OW:0] exp_period(input int cycles);
`ifdef PHASE_METER_PERIOD_EN
      return (cycles > 4095) ? 12'd4095 : 12'(cycles);
`else
      return (cycles > 0) ? '0 : '0;
`endif
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(output int ts);
      start = 1'b1;
      ts = t;
      step(1);
      start = 1'b0;
   endtask

   // Raise sig so the first synchronizer flop samples it while the timebase is at phase ph
   task automatic rise_at(input int ph, output int t0);
      int n = 0;
      bit hit = 0;
      while (!hit && n < 2 * PER) begin
         step(1);
         n++;
         hit = (n >= 3) && ((t % PER) == ph);
      end
      if (!hit) chk("rise_at_reached", 0, 1);
      sig = 1'b1;
      t0 = t;
   endtask

   task automatic wait_done(input int c0, input int lim);
      int n = 0;
      while (done_cnt == c0 && n < lim) begin
         @(negedge clk); #1;
         n++;
      end
      chk("done_seen", 32'(done_cnt > c0), 1);
      @(posedge clk); #1;
   endtask

   task automatic measure(input bit do_start, input int ph, input int hi, input int lo);
      int c0, ts, t0, t1, exp_t;
      c0 = done_cnt;
      if (do_start) begin
         pulse_start(ts);
         chk("busy_after_start", busy, 1);
      end
      rise_at(ph, t0);
      step(2);
      chk("offset_not_yet", offset, last_off);
      step(1);
      chk("offset_at_capture", offset, phase_word(ph));
      step(hi - 3);
      sig = 1'b0;
      step(lo);
      sig = 1'b1;
      t1 = t0 + hi + lo;
`ifdef PHASE_METER_PERIOD_EN
      exp_t = t1 + 3;
`else
      exp_t = t0 + 3;
`endif
      wait_done(c0, 50);
      chk("done_time", d_t, exp_t);
      chk("done_valid", d_valid, 1);
      chk("done_timeout", d_to, 0);
      chk("done_offset", d_off, phase_word(ph));
      chk("done_period", d_per, exp_period(hi + lo));
      last_off = phase_word(ph);
      last_per = exp_period(hi + lo);
      step(5);
      sig = 1'b0;
      step(5);
      chk("single_done_pulse", done_cnt, c0 + 1);
   endtask

   initial begin
      int c0, ts, t0, first, hi, lo;

      step(3);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_offset", offset, 0);
      chk("rst_period", period, 0);
      rst = 1'b0;
      step(1 + $urandom_range(0, 40));

      // Nominal edge, wrap boundary, and the borrow cases of the latency compensation
      measure(1, 100, HP, HP);
      measure(1, PER - 1, HP, HP);
      measure(1, 0, HP, HP);
      measure(1, HP + 1, HP, HP);
      measure(1, 1, HP, HP);

      for (int k = 0; k < 4; k++) begin
         hi = $urandom_range(4, 700);
         lo = $urandom_range(4, 700);
         step($urandom_range(0, 50));
         measure(1, $urandom_range(0, PER - 1), hi, lo);
      end

`ifdef PHASE_METER_PERIOD_EN
      measure(1, $urandom_range(0, PER - 1), 2100, 2100);
`endif

      // Start while sig is already high: must wait for it to drop before arming
      sig = 1'b1;
      step(10);
      c0 = done_cnt;
      pulse_start(ts);
      step(200);
      chk("hold_high_no_done", done_cnt, c0);
      chk("hold_high_busy", busy, 1);
      sig = 1'b0;
      measure(0, 300, HP, HP);

      // No edges at all: eight counted wraps force a timeout
      step($urandom_range(0, 700));
      c0 = done_cnt;
      pulse_start(ts);
      first = ((ts + 2 + HP - 1) / HP) * HP;
      wait_done(c0, 6000);
      chk("to_time", d_t, first + 7 * HP);
      chk("to_timeout", d_to, 1);
      chk("to_valid", d_valid, 0);
      chk("to_offset_held", d_off, last_off);
      chk("to_period_held", d_per, last_per);

      // Reset mid-measurement aborts silently and clears results
      step(7);
      c0 = done_cnt;
      pulse_start(ts);
`ifdef PHASE_METER_PERIOD_EN
      rise_at(200, t0);
      step(20);
`else
      step(20);
`endif
      rst = 1'b1;
      step(1);
      chk("abort_busy", busy, 0);
      chk("abort_offset", offset, 0);
      chk("abort_period", period, 0);
      chk("abort_done", done, 0);
      rst = 1'b0;
      sig = 1'b0;
      last_off = '0;
      last_per = '0;
      step(700);
      chk("abort_no_done", done_cnt, c0);
      measure(1, 10, HP, HP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
